line_copy_dma: RTL and testbench

AXI-Lite master that copies a run of 128-bit (16-byte) lines from a source address to a destination address in the shared SRAM, one line at a time: read one line, write it back with a fixed byte strobe, wait for the write response, advance. It sits directly upstream of the SRAM slave port; its read/write channel ports connect name-for-name to the SRAM's slave ports. A simple command/done handshake lets the control core launch jobs and collect status.

---
 rtl/line_copy_dma_pkg.sv | 28 ++
 rtl/line_copy_dma.sv | 195 +++++++++++++++++++
 tb/tb_line_copy_dma.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_copy_dma_pkg.sv
// Shared types and constants for the line copy DMA: state encoding, line geometry
// and the helper that aligns byte addresses to a line boundary.
package line_copy_dma_pkg;

  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = 16;
  localparam int LINE_W     = 128;
  localparam int STRB_W     = LINE_BYTES;
  localparam int MSG_W      = 32;
  localparam int OFF_W      = $clog2(LINE_BYTES);

  localparam logic [STRB_W-1:0] STRB_ALL  = 16'hFFFF;
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/line_copy_dma.sv
// AXI-Lite master copying a run of 16-byte lines from src to dst in shared SRAM,
// one line at a time: read, write with a fixed strobe, wait for response, advance.
module line_copy_dma
  import line_copy_dma_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  // job launch
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [LEN_W-1:0]    cmd_lines,
  input  logic [STRB_W-1:0]   cmd_strb,
  // completion
  output logic                done_valid,
  input  logic                done_ready,
  output logic [LEN_W-1:0]    done_lines,
  output logic                done_err,
  output logic                busy,
  // read address channel
  output logic [ADDR_W-1:0]   readAddr_addr,
  output logic                readAddr_valid,
  input  logic                readAddr_ready,
  // read data channel
  input  logic [LINE_W-1:0]   readData_data,
  input  logic                readData_valid,
  output logic                readData_ready,
  // write address channel
  output logic [ADDR_W-1:0]   writeAddr_addr,
  output logic                writeAddr_valid,
  input  logic                writeAddr_ready,
  // write data channel
  output logic [LINE_W-1:0]   writeData_data,
  output logic [STRB_W-1:0]   writeData_strb,
  output logic                writeData_valid,
  input  logic                writeData_ready,
  // write response channel
  input  logic [MSG_W-1:0]    writeResp_msg,
  input  logic                writeResp_valid,
  output logic                writeResp_ready
);

  state_e              r_state;
  state_e              w_state_nxt;

  logic [ADDR_W-1:0]   r_cur_src;
  logic [ADDR_W-1:0]   r_cur_dst;
  logic [LEN_W-1:0]    r_lines;
  logic [LEN_W-1:0]    r_count;
  logic [STRB_W-1:0]   r_strb;
  logic [LINE_W-1:0]   r_buf;
  logic                r_err;
  logic                r_aw_pend;
  logic                r_w_pend;

  logic [LEN_W-1:0]    w_count_inc;
  logic                w_more_lines;
  logic                w_aw_ok;
  logic                w_w_ok;
  logic                w_wr_req_done;

  assign w_count_inc   = r_count + LEN_W'(1);
  assign w_more_lines  = (w_count_inc < r_lines);

  // A write channel counts as done once it has handshaken, either earlier
  // (pending flag already cleared) or in the current cycle.
  assign w_aw_ok       = !r_aw_pend || writeAddr_ready;
  assign w_w_ok        = !r_w_pend  || writeData_ready;
  assign w_wr_req_done = w_aw_ok && w_w_ok;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------------
  // NOTE: the default is assigned before the case so no path leaves
  // w_state_nxt unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = (cmd_lines == '0) ? ST_DONE : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        if (readAddr_ready) w_state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (readData_valid) w_state_nxt = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (w_wr_req_done) w_state_nxt = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (writeResp_valid) begin
          w_state_nxt = w_more_lines ? ST_RD_ADDR : ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job registers, line buffer and write-channel pending flags
  // ---------------------------------------------------------------------------
  // NOTE: the line buffer is reset because it drives writeData_data directly
  // and must read 0 out of reset; a true RAM would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_src <= '0;
      r_cur_dst <= '0;
      r_lines   <= '0;
      r_count   <= '0;
      r_strb    <= '0;
      r_buf     <= '0;
      r_err     <= 1'b0;
      r_aw_pend <= 1'b0;
      r_w_pend  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_cur_src <= line_align(cmd_src);
            r_cur_dst <= line_align(cmd_dst);
            r_lines   <= cmd_lines;
            r_strb    <= cmd_strb;
            r_count   <= '0;
            r_err     <= 1'b0;
          end
        end
        ST_RD_DATA: begin
          if (readData_valid) begin
            r_buf     <= readData_data;
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          // Each channel drops its valid on its own handshake.
          if (writeAddr_ready) r_aw_pend <= 1'b0;
          if (writeData_ready) r_w_pend  <= 1'b0;
        end
        ST_WR_RESP: begin
          if (writeResp_valid) begin
            r_err     <= r_err | (writeResp_msg != '0);
            r_count   <= w_count_inc;
            r_cur_src <= r_cur_src + LINE_STEP;
            r_cur_dst <= r_cur_dst + LINE_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state or driven straight from registers
  // ---------------------------------------------------------------------------
  assign cmd_ready       = (r_state == ST_IDLE);
  assign busy            = (r_state != ST_IDLE);
  assign done_valid      = (r_state == ST_DONE);
  assign done_lines      = r_count;
  assign done_err        = r_err;

  assign readAddr_valid  = (r_state == ST_RD_ADDR);
  assign readAddr_addr   = r_cur_src;
  assign readData_ready  = (r_state == ST_RD_DATA);

  // Address, data and strobe stay put until the response is accepted.
  assign writeAddr_valid = r_aw_pend;
  assign writeAddr_addr  = r_cur_dst;
  assign writeData_valid = r_w_pend;
  assign writeData_data  = r_buf;
  assign writeData_strb  = r_strb;
  assign writeResp_ready = (r_state == ST_WR_RESP);

endmodule

// File: tb/tb_line_copy_dma.sv
// Directed bench for line_copy_dma: an SRAM slave model reacting on the falling
// edge, and one task per scenario with hand-computed expectations.
module tb_line_copy_dma;
  import line_copy_dma_pkg::*;

  localparam int LEN_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready;
  logic [31:0]       cmd_src, cmd_dst;
  logic [LEN_W-1:0]  cmd_lines;
  logic [15:0]       cmd_strb;
  logic              done_valid, done_ready;
  logic [LEN_W-1:0]  done_lines;
  logic              done_err, busy;
  logic [31:0]       readAddr_addr;
  logic              readAddr_valid, readAddr_ready;
  logic [127:0]      readData_data;
  logic              readData_valid, readData_ready;
  logic [31:0]       writeAddr_addr;
  logic              writeAddr_valid, writeAddr_ready;
  logic [127:0]      writeData_data;
  logic [15:0]       writeData_strb;
  logic              writeData_valid, writeData_ready;
  logic [31:0]       writeResp_msg;
  logic              writeResp_valid, writeResp_ready;

  always #5 clk = ~clk;

  line_copy_dma #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_lines(cmd_lines), .cmd_strb(cmd_strb),
    .done_valid(done_valid), .done_ready(done_ready), .done_lines(done_lines),
    .done_err(done_err), .busy(busy),
    .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid), .readAddr_ready(readAddr_ready),
    .readData_data(readData_data), .readData_valid(readData_valid), .readData_ready(readData_ready),
    .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid), .writeAddr_ready(writeAddr_ready),
    .writeData_data(writeData_data), .writeData_strb(writeData_strb),
    .writeData_valid(writeData_valid), .writeData_ready(writeData_ready),
    .writeResp_msg(writeResp_msg), .writeResp_valid(writeResp_valid), .writeResp_ready(writeResp_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // SRAM model: 256 lines, indexed by address bits [11:4].
  logic [127:0] mem [0:255];
  int           aw_delay = 0;
  int           err_line = -1;
  int           resp_idx = 0;
  int           n_rd = 0, n_aw = 0, n_av = 0;
  logic [31:0]  rd_log [0:63];
  logic [31:0]  wr_log [0:63];

  function automatic logic [127:0] pat(input int line);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'(line * 7 + k * 13 + 1);
    return v;
  endfunction

  // Slave: decides its inputs on the falling edge for the next rising edge.
  initial begin : slave
    bit           rd_pend, aw_got, w_got;
    logic [31:0]  rd_addr, aw_cap;
    logic [127:0] w_cap;
    logic [15:0]  s_cap;
    int           aw_cnt;
    rd_pend = 0; aw_got = 0; w_got = 0; aw_cnt = 0;
    rd_addr = '0; aw_cap = '0; w_cap = '0; s_cap = '0;
    readAddr_ready = 0; readData_valid = 0; readData_data = '0;
    writeAddr_ready = 0; writeData_ready = 0; writeResp_valid = 0; writeResp_msg = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_pend = 0; aw_got = 0; w_got = 0; aw_cnt = 0;
        readAddr_ready = 0; readData_valid = 0;
        writeAddr_ready = 0; writeData_ready = 0; writeResp_valid = 0; writeResp_msg = '0;
      end else begin
        if (readAddr_valid || writeAddr_valid) n_av++;
        readData_valid = 0;
        if (rd_pend && readData_ready) begin
          readData_valid = 1;
          readData_data  = mem[rd_addr[11:4]];
          rd_pend = 0;
        end
        readAddr_ready = 1;
        if (readAddr_valid) begin
          rd_pend = 1;
          rd_addr = readAddr_addr;
          if (n_rd < 64) rd_log[n_rd] = readAddr_addr;
          n_rd++;
        end
        writeResp_valid = 0;
        writeResp_msg   = '0;
        if (aw_got && w_got && writeResp_ready) begin
          for (int k = 0; k < 16; k++)
            if (s_cap[k]) mem[aw_cap[11:4]][8*k +: 8] = w_cap[8*k +: 8];
          writeResp_valid = 1;
          writeResp_msg   = (resp_idx == err_line) ? 32'd1 : 32'd0;
          resp_idx++;
          aw_got = 0;
          w_got  = 0;
        end
        writeAddr_ready = 0;
        if (writeAddr_valid) begin
          if (aw_cnt >= aw_delay) begin
            writeAddr_ready = 1;
            aw_cap = writeAddr_addr;
            aw_got = 1;
            aw_cnt = 0;
            if (n_aw < 64) wr_log[n_aw] = writeAddr_addr;
            n_aw++;
          end else begin
            aw_cnt++;
          end
        end
        writeData_ready = 0;
        if (writeData_valid) begin
          writeData_ready = 1;
          w_cap = writeData_data;
          s_cap = writeData_strb;
          w_got = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launches one job, waits for done, completes the done handshake.
  // cycles = falling edges after the accepting edge until done_valid is seen.
  task automatic run_job(input logic [31:0] src, input logic [31:0] dst,
                         input logic [LEN_W-1:0] lines, input logic [15:0] strb,
                         output int cycles, output logic [LEN_W-1:0] dl, output logic de);
    int n;
    @(negedge clk);
    cmd_src = src; cmd_dst = dst; cmd_lines = lines; cmd_strb = strb; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0;
    @(negedge clk);
    while (!done_valid && n < 2000) begin @(negedge clk); n++; end
    if (!done_valid) begin
      n_checks++; n_fail++;
      $display("FAIL job_timeout: done_valid not seen after %0d cycles", n);
    end
    cycles = n; dl = done_lines; de = done_err;
    done_ready = 1;
    @(negedge clk);
    done_ready = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    rst_n = 0; cmd_valid = 0; done_ready = 0;
    cmd_src = '0; cmd_dst = '0; cmd_lines = '0; cmd_strb = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b need 1", cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b need 0", busy); end
    n_checks++; if ({readAddr_valid, readData_ready, writeAddr_valid, writeData_valid, writeResp_ready, done_valid} !== 6'b0) begin
      n_fail++; $display("FAIL rst_valids: got %b need 000000", {readAddr_valid, readData_ready, writeAddr_valid, writeData_valid, writeResp_ready, done_valid}); end
    n_checks++; if ({readAddr_addr, writeAddr_addr, writeData_strb, done_lines, done_err} !== '0) begin
      n_fail++; $display("FAIL rst_regs: raddr %h waddr %h strb %h lines %0d err %b, need all 0",
                         readAddr_addr, writeAddr_addr, writeData_strb, done_lines, done_err); end
    n_checks++; if (writeData_data !== 128'd0) begin n_fail++; $display("FAIL rst_wdata: got %h need 0", writeData_data); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_copy4();
    int cyc; logic [LEN_W-1:0] dl; logic de;
    run_job(32'h0000_0000, 32'h0000_0100, 12'd4, STRB_ALL, cyc, dl, de);
    n_checks++; if (dl !== 12'd4) begin n_fail++; $display("FAIL copy4_lines: got %0d need 4", dl); end
    n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL copy4_err: got %b need 0", de); end
    n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL copy4_cycles: got %0d need 16", cyc); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (mem[16 + i] !== pat(i)) begin n_fail++; $display("FAIL copy4_data[%0d]: got %h need %h", i, mem[16 + i], pat(i)); end
    end
  endtask

  task automatic test_zero_lines();
    int cyc, av0, rd0; logic [LEN_W-1:0] dl; logic de;
    av0 = n_av; rd0 = n_rd;
    run_job(32'h0000_0400, 32'h0000_0800, 12'd0, STRB_ALL, cyc, dl, de);
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL zero_latency: got %0d need 0", cyc); end
    n_checks++; if (dl !== 12'd0) begin n_fail++; $display("FAIL zero_lines: got %0d need 0", dl); end
    n_checks++; if (n_av !== av0 || n_rd !== rd0) begin n_fail++; $display("FAIL zero_bus: got %0d addr-valid cycles need 0", n_av - av0); end
  endtask

  task automatic test_strobe();
    int cyc; logic [LEN_W-1:0] dl; logic de; logic [127:0] exp_line, src_line;
    mem[32] = {16{8'hAA}};
    src_line = pat(4);
    exp_line = {64'hAAAA_AAAA_AAAA_AAAA, src_line[63:0]};
    run_job(32'h0000_0040, 32'h0000_0200, 12'd1, 16'h00FF, cyc, dl, de);
    n_checks++; if (mem[32] !== exp_line) begin n_fail++; $display("FAIL strobe_data: got %h need %h", mem[32], exp_line); end
    n_checks++; if (dl !== 12'd1) begin n_fail++; $display("FAIL strobe_lines: got %0d need 1", dl); end
  endtask

  task automatic test_err_slow_aw();
    int cyc; logic [LEN_W-1:0] dl; logic de;
    aw_delay = 3;
    err_line = resp_idx + 1;
    run_job(32'h0000_0300, 32'h0000_0900, 12'd3, STRB_ALL, cyc, dl, de);
    aw_delay = 0;
    err_line = -1;
    n_checks++; if (dl !== 12'd3) begin n_fail++; $display("FAIL err_lines: got %0d need 3", dl); end
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b need 1", de); end
    n_checks++; if (cyc !== 21) begin n_fail++; $display("FAIL err_cycles: got %0d need 21", cyc); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (mem[144 + i] !== pat(48 + i)) begin n_fail++; $display("FAIL err_data[%0d]: got %h need %h", i, mem[144 + i], pat(48 + i)); end
    end
  endtask

  task automatic test_wrap_align();
    int cyc, rb, wb; logic [LEN_W-1:0] dl; logic de;
    rb = n_rd; wb = n_aw;
    run_job(32'hFFFF_FFF0, 32'h0000_0A0F, 12'd2, STRB_ALL, cyc, dl, de);
    n_checks++; if (rd_log[rb] !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL wrap_rd0: got %h need fffffff0", rd_log[rb]); end
    n_checks++; if (rd_log[rb + 1] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_rd1: got %h need 00000000", rd_log[rb + 1]); end
    n_checks++; if (wr_log[wb] !== 32'h0000_0A00 || wr_log[wb + 1] !== 32'h0000_0A10) begin
      n_fail++; $display("FAIL wrap_wr: got %h %h need 00000a00 00000a10", wr_log[wb], wr_log[wb + 1]); end
    n_checks++; if (mem[160] !== pat(255) || mem[161] !== pat(0)) begin n_fail++; $display("FAIL wrap_data: got %h %h", mem[160], mem[161]); end
    n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b need 0", de); end
    rb = n_rd;
    run_job(32'h0000_0007, 32'h0000_0B00, 12'd1, STRB_ALL, cyc, dl, de);
    n_checks++; if (rd_log[rb] !== 32'h0000_0000) begin n_fail++; $display("FAIL align_rd: got %h need 00000000", rd_log[rb]); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    cmd_src = 32'h0000_0050; cmd_dst = 32'h0000_0C00; cmd_lines = 12'd1; cmd_strb = STRB_ALL; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0;
    @(negedge clk);
    while (!done_valid && n < 200) begin @(negedge clk); n++; end
    n_checks++; if (done_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b need 1", done_valid); end
    // done handshake and a new zero-line command presented together
    done_ready = 1; cmd_valid = 1; cmd_lines = 12'd0;
    @(negedge clk);
    done_ready = 0;
    n_checks++; if (cmd_ready !== 1'b1 || done_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: cmd_ready %b done_valid %b need 1 0", cmd_ready, done_valid); end
    @(negedge clk);
    cmd_valid = 0;
    n_checks++; if (done_valid !== 1'b1 || done_lines !== 12'd0) begin
      n_fail++; $display("FAIL b2b_second: done_valid %b lines %0d need 1 0", done_valid, done_lines); end
    n_checks++; if (mem[192] !== pat(5)) begin n_fail++; $display("FAIL b2b_data: got %h need %h", mem[192], pat(5)); end
    done_ready = 1;
    @(negedge clk);
    done_ready = 0;
  endtask

  task automatic test_reset_mid_job();
    int n, rises, cyc; logic prev; logic [LEN_W-1:0] dl; logic de;
    @(negedge clk);
    cmd_src = 32'h0000_0000; cmd_dst = 32'h0000_0600; cmd_lines = 12'd3; cmd_strb = STRB_ALL; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0; rises = 0; prev = 0;
    while (rises < 2 && n < 200) begin
      @(negedge clk); n++;
      if (readData_ready && !prev) rises++;
      prev = readData_ready;
    end
    n_checks++; if (rises !== 2) begin n_fail++; $display("FAIL midrst_reach: saw %0d RD_DATA entries need 2", rises); end
    rst_n = 0;
    #1;
    n_checks++; if ({readAddr_valid, writeAddr_valid, writeData_valid, readData_ready, writeResp_ready, done_valid} !== 6'b0) begin
      n_fail++; $display("FAIL midrst_valids: got %b need 000000", {readAddr_valid, writeAddr_valid, writeData_valid, readData_ready, writeResp_ready, done_valid}); end
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: cmd_ready %b busy %b need 1 0", cmd_ready, busy); end
    n_checks++; if (readAddr_addr !== 32'd0 || writeData_strb !== 16'd0) begin
      n_fail++; $display("FAIL midrst_regs: raddr %h strb %h need 0 0", readAddr_addr, writeData_strb); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_job(32'h0000_0010, 32'h0000_0700, 12'd2, STRB_ALL, cyc, dl, de);
    n_checks++; if (dl !== 12'd2 || de !== 1'b0) begin n_fail++; $display("FAIL midrst_job: lines %0d err %b need 2 0", dl, de); end
    n_checks++; if (mem[112] !== pat(1) || mem[113] !== pat(2)) begin n_fail++; $display("FAIL midrst_data: got %h %h", mem[112], mem[113]); end
  endtask

  initial begin
    test_reset();
    test_copy4();
    test_zero_lines();
    test_strobe();
    test_err_slow_aw();
    test_wrap_align();
    test_back_to_back();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
